mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single-ported unified instruction/data memory of the pipelined core. Shares the port between the fetch stage (IF) and the memory stage (D) and produces the registered select that drives the 2:1 address/write-data muxes in front of the memory. Also produces per-requester done/stall signals for the hazard unit. Transactions are strictly serialised, with one outstanding access at a time.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_timer.sv | 31 +++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM state encoding and the
// select values that the datapath address/write-data muxes decode.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } arb_state_e;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_D  = 1'b1;

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: counts busy cycles without mem_ready and flags the cycle in
// which the count reaches TIMEOUT. Clear has priority over enable.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + W'(1);
  end

  // Expiry is the cycle whose increment would bring the count to TIMEOUT.
  assign expired = enable && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (D > IF) sequencer for the single-ported unified memory, one access in flight.
// Optional access watchdog under `MEMARB_TIMEOUT_EN`; without it err is tied low.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic d_req,
  input  logic d_we,
  input  logic mem_ready,
  output logic sel,
  output logic mem_req,
  output logic mem_we,
  output logic if_done,
  output logic d_done,
  output logic if_stall,
  output logic d_stall,
  output logic err
);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_e state_q, state_d;
  logic       sel_q, sel_d;
  logic       mem_we_q, mem_we_d;
  logic       mem_req_q, mem_req_d;
  logic       busy, done_fire, tmo_expired;

  assign busy      = (state_q != IDLE);
  assign done_fire = busy && (mem_ready || tmo_expired);

`ifdef MEMARB_TIMEOUT_EN
  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!busy || done_fire),
    .enable  (busy && !mem_ready),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= SEL_IF;
      mem_we_q  <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      mem_we_q  <= mem_we_d;
      mem_req_q <= mem_req_d;
    end
  end

  // On completion only the other requester may be granted directly; a repeat
  // request from the one just served has to pass through IDLE first.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    mem_we_d  = mem_we_q;
    mem_req_d = mem_req_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d = D_BUSY;  sel_d = SEL_D;  mem_we_d = d_we; mem_req_d = 1'b1;
        end else if (if_req) begin
          state_d = IF_BUSY; sel_d = SEL_IF; mem_we_d = 1'b0; mem_req_d = 1'b1;
        end
      end
      IF_BUSY: begin
        if (done_fire) begin
          if (d_req) begin
            state_d = D_BUSY; sel_d = SEL_D;  mem_we_d = d_we; mem_req_d = 1'b1;
          end else begin
            state_d = IDLE;   sel_d = SEL_IF; mem_we_d = 1'b0; mem_req_d = 1'b0;
          end
        end
      end
      D_BUSY: begin
        if (done_fire) begin
          if (if_req) begin
            state_d = IF_BUSY; sel_d = SEL_IF; mem_we_d = 1'b0; mem_req_d = 1'b1;
          end else begin
            state_d = IDLE;    sel_d = SEL_IF; mem_we_d = 1'b0; mem_req_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE; sel_d = SEL_IF; mem_we_d = 1'b0; mem_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    if_done  = (state_q == IF_BUSY) && done_fire;
    d_done   = (state_q == D_BUSY)  && done_fire;
    err      = busy && tmo_expired && !mem_ready;
    if_stall = rst_n && if_req && !if_done;
    d_stall  = rst_n && d_req  && !d_done;
  end

  assign sel     = sel_q;
  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter; timeout checks follow MEMARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic if_req, d_req, d_we, mem_ready;
  logic sel, mem_req, mem_we, if_done, d_done, if_stall, d_stall, err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .d_req     (d_req),
    .d_we      (d_we),
    .mem_ready (mem_ready),
    .sel       (sel),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .if_done   (if_done),
    .d_done    (d_done),
    .if_stall  (if_stall),
    .d_stall   (d_stall),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, then wait to the falling edge.
  task automatic step(input logic i, input logic d, input logic w, input logic r);
    @(posedge clk);
    #1;
    if_req = i; d_req = d; d_we = w; mem_ready = r;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic s, input logic rq, input logic w,
                            input logic ifd, input logic dd, input logic e);
    chk({tag, ".sel"},     sel,     s);
    chk({tag, ".mem_req"}, mem_req, rq);
    chk({tag, ".mem_we"},  mem_we,  w);
    chk({tag, ".if_done"}, if_done, ifd);
    chk({tag, ".d_done"},  d_done,  dd);
    chk({tag, ".err"},     err,     e);
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; mem_ready = 1'b1;
    #12;
    expect_out("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.if_stall", if_stall, 1'b0);
    chk("rst.d_stall",  d_stall,  1'b0);
    @(posedge clk); #1;
    if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    rst_n = 1'b1;

    // IF only, three-cycle access, then re-request through IDLE with a dropped request
    step(1, 0, 0, 0); expect_out("if.idle", 0, 0, 0, 0, 0, 0);
    chk("if.stall_idle", if_stall, 1'b1);
    step(1, 0, 0, 0); expect_out("if.b1", 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0); expect_out("if.b2", 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1); expect_out("if.b3", 0, 1, 0, 1, 0, 0);
    chk("if.stall_done", if_stall, 1'b0);
    step(1, 0, 0, 0); expect_out("if.reidle", 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1); expect_out("if.drop", 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1); expect_out("idle.rdy_ignored", 0, 0, 0, 0, 0, 0);

    // Both request: D first, IF follows with no bubble
    step(1, 1, 0, 0); expect_out("both.idle", 0, 0, 0, 0, 0, 0);
    chk("both.d_stall", d_stall, 1'b1);
    step(1, 1, 0, 1); expect_out("both.d", 1, 1, 0, 0, 1, 0);
    chk("both.if_stall", if_stall, 1'b1);
    step(1, 0, 0, 0); expect_out("both.if1", 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1); expect_out("both.if2", 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0); expect_out("both.end", 0, 0, 0, 0, 0, 0);

    // D write completing in its first cycle; then d_we changing after grant is ignored
    step(0, 1, 1, 0); expect_out("wr.idle", 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1); expect_out("wr.busy", 1, 1, 1, 0, 1, 0);
    step(0, 0, 0, 0); expect_out("wr.end", 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0); expect_out("rd.idle", 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0); expect_out("rd.b1", 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1); expect_out("rd.b2", 1, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0); expect_out("rd.end", 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a D access
    step(0, 1, 0, 0); expect_out("rs.idle", 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0); expect_out("rs.busy", 1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    expect_out("rs.held", 0, 0, 0, 0, 0, 0);
    chk("rs.d_stall", d_stall, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    expect_out("rs.rel", 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0); expect_out("rs.regrant", 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1); expect_out("rs.done", 1, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0); expect_out("rs.end", 0, 0, 0, 0, 0, 0);

    // Long wait without mem_ready: watchdog fires on the 4th busy cycle when enabled
    step(0, 1, 0, 0); expect_out("to.idle", 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 0, 0); expect_out("to.wait", 1, 1, 0, 0, 0, 0);
    end
`ifdef MEMARB_TIMEOUT_EN
    step(0, 1, 0, 0); expect_out("to.expire", 1, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0); expect_out("to.reidle", 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 0, 0); expect_out("to.wait2", 1, 1, 0, 0, 0, 0);
    end
    step(0, 1, 0, 1); expect_out("to.rdy_wins", 1, 1, 0, 0, 1, 0);
`else
    for (int k = 4; k <= 9; k++) begin
      step(0, 1, 0, 0); expect_out("nt.wait", 1, 1, 0, 0, 0, 0);
    end
    step(0, 1, 0, 1); expect_out("nt.done", 1, 1, 0, 0, 1, 0);
`endif
    step(0, 0, 0, 0); expect_out("to.end", 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
